// File: rtl/vram_dblbuf_fill.sv
// Double-buffered framebuffer with a rectangle fill engine and a vsync-synchronised
// bank swap. The CPU port and the fill engine write the back bank while the scanout
// reads the front bank through a registered, never-stalling read port.
module vram_dblbuf_fill #(
  parameter int FB_W   = 640,
  parameter int FB_H   = 240,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 20,
  parameter int XY_W   = 10
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  // CPU port (back bank)
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [PIX_W-1:0]  cpu_rdata,
  output logic              cpu_rvalid,
  output logic              busy,
  // Fill engine
  input  logic              fill_req,
  input  logic [XY_W-1:0]   fill_x,
  input  logic [XY_W-1:0]   fill_y,
  input  logic [XY_W-1:0]   fill_w,
  input  logic [XY_W-1:0]   fill_h,
  input  logic [PIX_W-1:0]  fill_colour,
  output logic              fill_ack,
  // Bank swap
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_done,
  output logic              front_sel,
  // Scanout port (front bank)
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [PIX_W-1:0]  scan_data
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);
  localparam logic [31:0]      FB_W_U   = 32'(FB_W);
  localparam logic [31:0]      FB_H_U   = 32'(FB_H);
  localparam logic [IDX_W-1:0] FB_W_IDX = IDX_W'(FB_W);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [XY_W-1:0]  ONE_XY   = XY_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ACK
  } state_e;

  // Pixel storage: bank0 / bank1
  logic [PIX_W-1:0] bank0 [DEPTH];
  logic [PIX_W-1:0] bank1 [DEPTH];

  // Registered state
  state_e           state_q, state_d;
  logic [IDX_W-1:0] fill_addr_q, fill_addr_d;
  logic [IDX_W-1:0] row_base_q, row_base_d;
  logic [XY_W-1:0]  col_q, col_d;
  logic [XY_W-1:0]  row_q, row_d;
  logic [XY_W-1:0]  w_q, w_d;
  logic [XY_W-1:0]  h_q, h_d;
  logic [PIX_W-1:0] colour_q, colour_d;
  logic             front_sel_q, front_sel_d;
  logic             pending_q, pending_d;
  logic             swap_done_q;
  logic             rvalid_q;
  logic [PIX_W-1:0] cpu_rdata_q;
  logic [PIX_W-1:0] scan_data_q;

  // Combinational helpers
  logic             idle;
  logic             cpu_in_range, scan_in_range;
  logic [IDX_W-1:0] cpu_idx, scan_idx;
  logic             cpu_rd;
  logic             swap_fire;
  logic             x_ok, y_ok, fill_null;
  logic [31:0]      rem_w, rem_h, origin;
  logic [XY_W-1:0]  w_clip, h_clip;
  logic             wr_en, wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [PIX_W-1:0] wr_data;

  assign idle          = (state_q == S_IDLE);
  assign cpu_in_range  = (32'(cpu_addr) < DEPTH_U);
  assign scan_in_range = (32'(scan_addr) < DEPTH_U);
  assign cpu_idx       = cpu_addr[IDX_W-1:0];
  assign scan_idx      = scan_addr[IDX_W-1:0];
  assign cpu_rd        = idle && cpu_re && !cpu_we;

  // Swap is taken on frame_end only while the fill engine is idle; a swap_req arriving
  // together with frame_end counts as already pending.
  assign swap_fire   = frame_end && (pending_q || swap_req) && idle;
  assign front_sel_d = front_sel_q ^ swap_fire;
  assign pending_d   = swap_fire ? 1'b0 : (pending_q || swap_req);

  // Rectangle clipping against the framebuffer edges; the origin multiply happens once
  // at latch time, the fill loop itself only adds.
  assign x_ok      = (32'(fill_x) < FB_W_U);
  assign y_ok      = (32'(fill_y) < FB_H_U);
  assign rem_w     = FB_W_U - 32'(fill_x);
  assign rem_h     = FB_H_U - 32'(fill_y);
  assign w_clip    = (32'(fill_w) > rem_w) ? XY_W'(rem_w) : fill_w;
  assign h_clip    = (32'(fill_h) > rem_h) ? XY_W'(rem_h) : fill_h;
  assign origin    = 32'(fill_y) * FB_W_U + 32'(fill_x);
  assign fill_null = !x_ok || !y_ok || (w_clip == '0) || (h_clip == '0);

  // Back-bank write port: fill engine owns it while filling, otherwise the idle CPU.
  // A CPU access on the swap edge uses the post-swap bank assignment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_en   = 1'b0;
    wr_bank = ~front_sel_q;
    wr_idx  = fill_addr_q;
    wr_data = colour_q;
    if (state_q == S_FILL) begin
      wr_en = 1'b1;
    end else if (idle && cpu_we && cpu_in_range) begin
      wr_en   = 1'b1;
      wr_bank = ~front_sel_d;
      wr_idx  = cpu_idx;
      wr_data = cpu_wdata;
    end
  end

  // Bank storage and registered read ports.
  // NOTE: RAM arrays and their output registers carry no reset so they map onto block RAM;
  // validity is carried by cpu_rvalid and the fixed scanout latency instead.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) bank0[wr_idx] <= wr_data;
    if (wr_en &&  wr_bank) bank1[wr_idx] <= wr_data;
    if (cpu_rd) begin
      if (!cpu_in_range)    cpu_rdata_q <= '0;
      else if (front_sel_d) cpu_rdata_q <= bank0[cpu_idx];
      else                  cpu_rdata_q <= bank1[cpu_idx];
    end
    if (!scan_in_range)     scan_data_q <= '0;
    else if (front_sel_q)   scan_data_q <= bank1[scan_idx];
    else                    scan_data_q <= bank0[scan_idx];
  end

  // Fill FSM next-state and datapath: row-major walk, row start advanced by FB_W.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    row_base_d  = row_base_q;
    col_d       = col_q;
    row_d       = row_q;
    w_d         = w_q;
    h_d         = h_q;
    colour_d    = colour_q;
    case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          w_d         = w_clip;
          h_d         = h_clip;
          colour_d    = fill_colour;
          col_d       = '0;
          row_d       = '0;
          row_base_d  = IDX_W'(origin);
          fill_addr_d = IDX_W'(origin);
          state_d     = fill_null ? S_ACK : S_FILL;
        end
      end
      S_FILL: begin
        if (col_q == w_q - ONE_XY) begin
          col_d = '0;
          if (row_q == h_q - ONE_XY) begin
            state_d = S_ACK;
          end else begin
            row_d       = row_q + ONE_XY;
            row_base_d  = row_base_q + FB_W_IDX;
            fill_addr_d = row_base_q + FB_W_IDX;
          end
        end else begin
          col_d       = col_q + ONE_XY;
          fill_addr_d = fill_addr_q + ONE_IDX;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and fill registers; reset aborts any fill in progress without an ack.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fill_addr_q <= '0;
      row_base_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      colour_q    <= '0;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      row_base_q  <= row_base_d;
      col_q       <= col_d;
      row_q       <= row_d;
      w_q         <= w_d;
      h_q         <= h_d;
      colour_q    <= colour_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_fire;
      rvalid_q    <= cpu_rd;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign fill_ack   = (state_q == S_ACK);
  assign swap_done  = swap_done_q;
  assign front_sel  = front_sel_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign scan_data  = scan_data_q;

endmodule

// File: tb/tb_vram_dblbuf_fill.sv
// Directed self-checking bench for vram_dblbuf_fill: CPU access, fills with clipping,
// swap timing (plain, deferred by a fill, coincident request) and reset mid-fill.
module tb_vram_dblbuf_fill;

  localparam int ADDR_W = 20;
  localparam int PIX_W  = 8;
  localparam int XY_W   = 10;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic [PIX_W-1:0]  cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [PIX_W-1:0]  cpu_rdata;
  logic              cpu_rvalid;
  logic              busy;
  logic              fill_req;
  logic [XY_W-1:0]   fill_x, fill_y, fill_w, fill_h;
  logic [PIX_W-1:0]  fill_colour;
  logic              fill_ack;
  logic              swap_req;
  logic              frame_end;
  logic              swap_done;
  logic              front_sel;
  logic [ADDR_W-1:0] scan_addr;
  logic [PIX_W-1:0]  scan_data;

  int tests = 0;
  int fails = 0;

  vram_dblbuf_fill dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_re      (cpu_re),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .busy        (busy),
    .fill_req    (fill_req),
    .fill_x      (fill_x),
    .fill_y      (fill_y),
    .fill_w      (fill_w),
    .fill_h      (fill_h),
    .fill_colour (fill_colour),
    .fill_ack    (fill_ack),
    .swap_req    (swap_req),
    .frame_end   (frame_end),
    .swap_done   (swap_done),
    .front_sel   (front_sel),
    .scan_addr   (scan_addr),
    .scan_data   (scan_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int addr, input logic [7:0] data);
    cpu_addr  = ADDR_W'(addr);
    cpu_wdata = data;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic cpu_read(input int addr, input logic [7:0] exp, input string tag);
    cpu_addr = ADDR_W'(addr);
    cpu_re   = 1'b1;
    tick();
    cpu_re   = 1'b0;
    check({tag, "_rvalid"}, 32'(cpu_rvalid), 32'(1));
    check(tag, 32'(cpu_rdata), 32'(exp));
  endtask

  task automatic scan_read(input int addr, input logic [7:0] exp, input string tag);
    scan_addr = ADDR_W'(addr);
    tick();
    check(tag, 32'(scan_data), 32'(exp));
  endtask

  task automatic start_fill(input int x, input int y, input int w, input int h,
                            input logic [7:0] c);
    fill_x      = XY_W'(x);
    fill_y      = XY_W'(y);
    fill_w      = XY_W'(w);
    fill_h      = XY_W'(h);
    fill_colour = c;
    fill_req    = 1'b1;
  endtask

  // Run a fill, checking busy and the ack position every cycle; ack expected after n_ack edges.
  task automatic run_fill(input int x, input int y, input int w, input int h,
                          input logic [7:0] c, input int n_ack, input string tag);
    start_fill(x, y, w, h, c);
    for (int k = 1; k <= n_ack + 1; k++) begin
      tick();
      if (k == 1) fill_req = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'(k <= n_ack));
      check({tag, "_ack"}, 32'(fill_ack), 32'(k == n_ack));
    end
  endtask

  int clr_list[18] = '{2, 637, 638, 639, 640, 641, 642, 643, 644, 645,
                       1281, 1282, 1283, 1284, 1285, 1922, 100, 0};

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_req = 1'b0; fill_x = '0; fill_y = '0; fill_w = '0; fill_h = '0; fill_colour = '0;
    swap_req = 1'b0; frame_end = 1'b0; scan_addr = '0;

    // Reset state
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rvalid", 32'(cpu_rvalid), 32'(0));
    check("rst_ack", 32'(fill_ack), 32'(0));
    check("rst_swap_done", 32'(swap_done), 32'(0));
    check("rst_front_sel", 32'(front_sel), 32'(0));
    rst = 1'b1;
    tick();

    // Clear pixels around the fill targets in the back bank (bank1)
    foreach (clr_list[i]) cpu_write(clr_list[i], 8'h00);

    // CPU write / read-back; front bank must not see it
    cpu_write(100, 8'h5A);
    cpu_read(100, 8'h5A, "cpu_rd100");
    tick();
    check("rvalid_pulse", 32'(cpu_rvalid), 32'(0));
    scan_addr = ADDR_W'(100);
    tick();
    tests++;
    assert (scan_data !== 8'h5A) else begin
      fails++;
      $error("FAIL scan_front_100: observed %0h expected not 5a", scan_data);
    end

    // Out-of-range write dropped, read returns 0 with rvalid
    cpu_write(153600, 8'h77);
    cpu_read(153600, 8'h00, "cpu_oor");

    // 3x2 fill at (2,1): ack after 7 edges
    run_fill(2, 1, 3, 2, 8'h11, 7, "fill6");
    cpu_read(642, 8'h11, "f6_642");
    cpu_read(643, 8'h11, "f6_643");
    cpu_read(644, 8'h11, "f6_644");
    cpu_read(1282, 8'h11, "f6_1282");
    cpu_read(1283, 8'h11, "f6_1283");
    cpu_read(1284, 8'h11, "f6_1284");
    cpu_read(641, 8'h00, "f6_n641");
    cpu_read(645, 8'h00, "f6_n645");
    cpu_read(1281, 8'h00, "f6_n1281");
    cpu_read(1285, 8'h00, "f6_n1285");
    cpu_read(2, 8'h00, "f6_n2");
    cpu_read(1922, 8'h00, "f6_n1922");

    // Clipped fill at x=638: two pixels, ack after 3 edges
    run_fill(638, 0, 10, 1, 8'h22, 3, "fillclip");
    cpu_read(637, 8'h00, "clip_n637");
    cpu_read(638, 8'h22, "clip_638");
    cpu_read(639, 8'h22, "clip_639");
    cpu_read(640, 8'h00, "clip_n640");

    // Zero width and off-screen origin: ack straight away
    run_fill(5, 5, 0, 4, 8'hEE, 1, "fillw0");
    run_fill(700, 0, 4, 4, 8'hEE, 1, "fillxoob");
    cpu_read(0, 8'h00, "w0_nowrite");

    // Swap: request, frame_end 50 cycles later
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (49) tick();
    check("swap_wait_sel", 32'(front_sel), 32'(0));
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("swap1_sel", 32'(front_sel), 32'(1));
    check("swap1_done", 32'(swap_done), 32'(1));
    tick();
    check("swap1_done_pulse", 32'(swap_done), 32'(0));
    scan_read(642, 8'h11, "scan_642");
    scan_read(1284, 8'h11, "scan_1284");
    scan_read(100, 8'h5A, "scan_100");
    scan_read(639, 8'h22, "scan_639");

    // 1000-pixel fill into bank0; frame_end during the fill must not swap
    start_fill(0, 10, 100, 10, 8'h33);
    for (int k = 1; k <= 1002; k++) begin
      tick();
      if (k == 1) fill_req = 1'b0;
      check("big_busy", 32'(busy), 32'(k <= 1001));
      check("big_ack", 32'(fill_ack), 32'(k == 1001));
      if (k == 3) begin
        cpu_addr = ADDR_W'(641); cpu_wdata = 8'hEE; cpu_we = 1'b1;
      end
      if (k == 4) begin
        cpu_we = 1'b0; cpu_addr = ADDR_W'(642); cpu_re = 1'b1;
      end
      if (k == 5) begin
        check("busy_rvalid", 32'(cpu_rvalid), 32'(0));
        cpu_re = 1'b0;
      end
      if (k == 10) swap_req = 1'b1;
      if (k == 11) swap_req = 1'b0;
      if (k == 500) frame_end = 1'b1;
      if (k == 501) begin
        frame_end = 1'b0;
        check("defer_sel", 32'(front_sel), 32'(1));
        check("defer_done", 32'(swap_done), 32'(0));
      end
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("swap2_sel", 32'(front_sel), 32'(0));
    check("swap2_done", 32'(swap_done), 32'(1));
    scan_read(6400, 8'h33, "big_first");
    scan_read(6499, 8'h33, "big_row0_end");
    scan_read(7040, 8'h33, "big_row1");
    scan_read(12259, 8'h33, "big_last");
    cpu_read(641, 8'h00, "busy_we_dropped");
    cpu_read(642, 8'h11, "back_bank1");

    // swap_req coincident with frame_end
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    check("swap3_sel", 32'(front_sel), 32'(1));
    check("swap3_done", 32'(swap_done), 32'(1));

    // Reset mid-fill into bank0: five pixels written, then abort
    start_fill(0, 20, 100, 10, 8'h44);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) fill_req = 1'b0;
      check("mid_busy", 32'(busy), 32'(1));
    end
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_ack", 32'(fill_ack), 32'(0));
    check("midrst_sel", 32'(front_sel), 32'(0));
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_ack", 32'(fill_ack), 32'(0));
      check("post_rst_busy", 32'(busy), 32'(0));
    end
    scan_read(12800, 8'h44, "persist_12800");
    scan_read(12804, 8'h44, "persist_12804");
    scan_read(6400, 8'h33, "persist_6400");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
